// File: rtl/buf_kernel_pkg.sv
// Shared defaults, derived word counts and FSM state type for the ping-pong kernel buffer.
package buf_kernel_pkg;

    localparam int COMPLXLEN_DEF = 32;
    localparam int REPLLEN_DEF   = 4;
    localparam int PARAKRN_DEF   = 64;
    localparam int DEPTH_DEF     = 16;
    localparam int INWIDTH_DEF   = 64;
    localparam int SELPW_DEF     = 8;
    localparam int KPW_DEF       = INWIDTH_DEF / COMPLXLEN_DEF;

    localparam int KWORDS = PARAKRN_DEF * DEPTH_DEF / KPW_DEF;
    localparam int SWORDS = PARAKRN_DEF * DEPTH_DEF / SELPW_DEF;

    typedef enum logic {
        LOAD = 1'b0,
        FULL = 1'b1
    } state_t;

endpackage

// File: rtl/buf_kernel_bank.sv
// One lane's two-page RAM: kernel and select fields are written independently,
// reads are registered and the read register is the only reset state.
module buf_kernel_bank
    import buf_kernel_pkg::*;
#(
    parameter int COMPLXLEN = COMPLXLEN_DEF,
    parameter int REPLLEN   = REPLLEN_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int INDXLEN   = $clog2(DEPTH),
    localparam int W        = COMPLXLEN + REPLLEN + 1
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wpage,
    input  logic [INDXLEN-1:0]   waddr,
    input  logic                 kern_we,
    input  logic                 sel_we,
    input  logic [COMPLXLEN-1:0] kern_data,
    input  logic [REPLLEN:0]     sel_data,
    input  logic                 rd_en,
    input  logic                 rpage,
    input  logic [INDXLEN-1:0]   raddr,
    output logic [W-1:0]         rd_data
);

    logic [W-1:0]       mem [2*DEPTH];
    logic [INDXLEN:0]   wa;
    logic [INDXLEN:0]   ra;

    assign wa = {wpage, waddr};
    assign ra = {rpage, raddr};

    always_ff @(posedge clk) begin
        if (kern_we) mem[wa][COMPLXLEN-1:0] <= kern_data;
        if (sel_we)  mem[wa][W-1:COMPLXLEN] <= sel_data;
    end

    // read stage: data holds between strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        rd_data <= '0;
        else if (rd_en) rd_data <= mem[ra];
    end

endmodule

// File: rtl/buf_kernel_pingpong.sv
// Double-buffered kernel/select store: words stream into the shadow page while the
// MAC lanes read the active page; a swap handshake exchanges the two pages.
module buf_kernel_pingpong
    import buf_kernel_pkg::*;
#(
    parameter int COMPLXLEN = COMPLXLEN_DEF,
    parameter int REPLLEN   = REPLLEN_DEF,
    parameter int PARAKRN   = PARAKRN_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int INWIDTH   = INWIDTH_DEF,
    parameter int SELPW     = SELPW_DEF,
    localparam int KPW      = INWIDTH / COMPLXLEN,
    localparam int INDXLEN  = $clog2(DEPTH),
    localparam int W        = COMPLXLEN + REPLLEN + 1
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_iskern,
    input  logic                 in_issel,
    input  logic [INWIDTH-1:0]   in_data,
    output logic                 shadow_full,
    input  logic                 swap_req,
    output logic                 swap_ack,
    input  logic                 rd_en,
    input  logic [INDXLEN-1:0]   rd_addr,
    output logic                 rd_valid,
    output logic [PARAKRN*W-1:0] rd_data,
    output logic                 err
);

    localparam int NKW = PARAKRN * DEPTH / KPW;
    localparam int NSW = PARAKRN * DEPTH / SELPW;
    localparam int KCW = $clog2(NKW);
    localparam int SCW = $clog2(NSW);

    state_t             state;
    state_t             state_nxt;
    logic               active;
    logic [KCW-1:0]     kc;
    logic [SCW-1:0]     sc;
    logic               kern_done;
    logic               sel_done;
    logic               xfer;
    logic               kern_wr;
    logic               sel_wr;
    logic               kern_last;
    logic               sel_last;
    logic               bad_word;
    logic               swap;
    logic [INDXLEN-1:0] waddr;

    // A word is dropped (and flagged) unless it is exactly one kind and that stream is still open.
    assign xfer      = in_valid & in_ready;
    assign kern_wr   = xfer & in_iskern & ~in_issel & ~kern_done;
    assign sel_wr    = xfer & in_issel & ~in_iskern & ~sel_done;
    assign bad_word  = xfer & ~kern_wr & ~sel_wr;
    assign kern_last = kern_wr & (kc == KCW'(NKW - 1));
    assign sel_last  = sel_wr & (sc == SCW'(NSW - 1));
    assign swap      = (state == FULL) & swap_req;
    assign waddr     = in_iskern ? kc[INDXLEN-1:0] : sc[INDXLEN-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= LOAD;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:    if ((kern_done | kern_last) & (sel_done | sel_last)) state_nxt = FULL;
            FULL:    if (swap_req) state_nxt = LOAD;
            default: state_nxt = LOAD;
        endcase
    end

    always_comb begin
        in_ready    = 1'b0;
        shadow_full = 1'b0;
        swap_ack    = 1'b0;
        case (state)
            LOAD:    in_ready = 1'b1;
            FULL: begin
                shadow_full = 1'b1;
                swap_ack    = swap_req;
            end
            default: in_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kc        <= '0;
            sc        <= '0;
            kern_done <= 1'b0;
            sel_done  <= 1'b0;
            active    <= 1'b0;
            err       <= 1'b0;
            rd_valid  <= 1'b0;
        end else begin
            if (swap) begin
                kc        <= '0;
                sc        <= '0;
                kern_done <= 1'b0;
                sel_done  <= 1'b0;
                active    <= ~active;
            end else begin
                if (kern_wr) kc <= kc + 1'b1;
                if (sel_wr)  sc <= sc + 1'b1;
                if (kern_last) kern_done <= 1'b1;
                if (sel_last)  sel_done  <= 1'b1;
            end
            if (bad_word) err <= 1'b1;
            rd_valid <= rd_en;
        end
    end

    // Lane decode: the upper counter bits pick the bank group, the word slot picks the field.
    for (genvar b = 0; b < PARAKRN; b++) begin : g_bank
        localparam int KG = b / KPW;
        localparam int KJ = b % KPW;
        localparam int SG = b / SELPW;
        localparam int SJ = b % SELPW;

        logic kern_we;
        logic sel_we;

        assign kern_we = kern_wr & (kc[KCW-1:INDXLEN] == (KCW - INDXLEN)'(KG));
        assign sel_we  = sel_wr  & (sc[SCW-1:INDXLEN] == (SCW - INDXLEN)'(SG));

        buf_kernel_bank #(
            .COMPLXLEN (COMPLXLEN),
            .REPLLEN   (REPLLEN),
            .DEPTH     (DEPTH),
            .INDXLEN   (INDXLEN)
        ) u_bank (
            .clk       (clk),
            .rst       (rst),
            .wpage     (~active),
            .waddr     (waddr),
            .kern_we   (kern_we),
            .sel_we    (sel_we),
            .kern_data (in_data[KJ*COMPLXLEN +: COMPLXLEN]),
            .sel_data  (in_data[SJ*(REPLLEN+1) +: REPLLEN+1]),
            .rd_en     (rd_en),
            .rpage     (active),
            .raddr     (rd_addr),
            .rd_data   (rd_data[b*W +: W])
        );
    end

endmodule

// File: tb/tb_buf_kernel_pingpong.sv
// Randomised bench for buf_kernel_pingpong: a word-list model of both pages predicts every lane read.
module tb_buf_kernel_pingpong;
    import buf_kernel_pkg::*;

    localparam int NB = 64;
    localparam int D  = 16;
    localparam int W  = 37;
    localparam int LW = NB * W;
    localparam int KW = KWORDS;
    localparam int SW = SWORDS;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic          in_iskern;
    logic          in_issel;
    logic [63:0]   in_data;
    logic          shadow_full;
    logic          swap_req;
    logic          swap_ack;
    logic          rd_en;
    logic [3:0]    rd_addr;
    logic          rd_valid;
    logic [LW-1:0] rd_data;
    logic          err;

    buf_kernel_pingpong dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_iskern   (in_iskern),
        .in_issel    (in_issel),
        .in_data     (in_data),
        .shadow_full (shadow_full),
        .swap_req    (swap_req),
        .swap_ack    (swap_ack),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: physical contents of both pages as the word lists that filled them.
    logic [63:0] pg_kw [2][KW];
    logic [63:0] pg_sw [2][SW];
    int          active_m;
    int          kc_m;
    int          sc_m;
    logic        err_m;
    int          n_checks;
    int          n_err;

    function automatic logic [LW-1:0] exp_line(input int pg, input int a);
        logic [LW-1:0] r;
        logic [63:0]   kw;
        logic [63:0]   sw;
        r = '0;
        for (int b = 0; b < NB; b++) begin
            kw = pg_kw[pg][(b/2)*D + a];
            sw = pg_sw[pg][(b/8)*D + a];
            r[b*W +: W] = {sw[(b%8)*5 +: 5], kw[(b%2)*32 +: 32]};
        end
        return r;
    endfunction

    function automatic int diff_lane(input logic [LW-1:0] x, input logic [LW-1:0] y);
        for (int b = 0; b < NB; b++)
            if (x[b*W +: W] !== y[b*W +: W]) return b;
        return 0;
    endfunction

    task automatic clk_step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic k, input logic s, input logic [63:0] d);
        logic acc;
        in_valid = 1'b1; in_iskern = k; in_issel = s; in_data = d;
        acc = in_ready;
        clk_step();
        in_valid = 1'b0; in_iskern = 1'b0; in_issel = 1'b0; rd_en = 1'b0;
        if (acc) begin
            if (k && !s) begin
                if (kc_m < KW) begin pg_kw[active_m ^ 1][kc_m] = d; kc_m++; end
                else err_m = 1'b1;
            end else if (s && !k) begin
                if (sc_m < SW) begin pg_sw[active_m ^ 1][sc_m] = d; sc_m++; end
                else err_m = 1'b1;
            end else begin
                err_m = 1'b1;
            end
        end
    endtask

    // mode 0: all kernel then all select; mode 1: one-for-one with random idle gaps
    task automatic load_page(input int mode, input int nk, input int ns,
                             output int sf_bad, output int ack_seen);
        int   k;
        int   s;
        logic use_sel;
        logic full;
        k = 0; s = 0; sf_bad = 0; ack_seen = 0;
        while (k < nk || s < ns) begin
            if (mode == 1 && $urandom_range(0, 3) == 0) begin
                clk_step();
            end else begin
                use_sel = (s < ns) && (k >= nk || (mode == 1 && k > s));
                if (use_sel) begin put(1'b0, 1'b1, {$urandom, $urandom}); s++; end
                else         begin put(1'b1, 1'b0, {$urandom, $urandom}); k++; end
            end
            full = (kc_m == KW) && (sc_m == SW);
            if (shadow_full !== full || in_ready !== !full) sf_bad++;
            if (swap_ack === 1'b1 && !full) ack_seen++;
        end
    endtask

    task automatic swap_pages(output logic ack);
        swap_req = 1'b1;
        #1 ack = swap_ack;
        clk_step();
        swap_req = 1'b0;
        active_m ^= 1; kc_m = 0; sc_m = 0;
    endtask

    task automatic apply_reset();
        in_valid = 0; in_iskern = 0; in_issel = 0; in_data = '0;
        swap_req = 0; rd_en = 0; rd_addr = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        active_m = 0; kc_m = 0; sc_m = 0; err_m = 1'b0;
    endtask

    task automatic test_reset();
        in_valid = 0; in_iskern = 0; in_issel = 0; in_data = '0;
        swap_req = 0; rd_en = 0; rd_addr = '0;
        rst = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_checks += 6;
        if (in_ready !== 1'b1)    begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        if (shadow_full !== 1'b0) begin n_err++; $display("FAIL reset_shadow_full got=%b exp=0", shadow_full); end
        if (swap_ack !== 1'b0)    begin n_err++; $display("FAIL reset_swap_ack got=%b exp=0", swap_ack); end
        if (rd_valid !== 1'b0)    begin n_err++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
        if (rd_data !== '0)       begin n_err++; $display("FAIL reset_rd_data lane0 got=%h exp=0", rd_data[W-1:0]); end
        if (err !== 1'b0)         begin n_err++; $display("FAIL reset_err got=%b exp=0", err); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        active_m = 0; kc_m = 0; sc_m = 0; err_m = 1'b0;
    endtask

    task automatic test_basic();
        int            sf_bad, ack_seen, l;
        logic          ack;
        logic [LW-1:0] expv;
        load_page(0, KW, SW, sf_bad, ack_seen);
        n_checks++;
        if (sf_bad != 0) begin n_err++; $display("FAIL basic_full_timing bad_cycles=%0d exp=0", sf_bad); end
        swap_pages(ack);
        n_checks += 2;
        if (ack !== 1'b1) begin n_err++; $display("FAIL basic_swap_ack got=%b exp=1", ack); end
        if (in_ready !== 1'b1 || shadow_full !== 1'b0) begin
            n_err++; $display("FAIL basic_after_swap in_ready=%b shadow_full=%b exp 1/0", in_ready, shadow_full);
        end
        for (int a = 0; a < D; a++) begin
            rd_en = 1'b1; rd_addr = 4'(a);
            clk_step();
            rd_en = 1'b0;
            expv = exp_line(active_m, a);
            n_checks++;
            if (rd_valid !== 1'b1 || rd_data !== expv) begin
                n_err++; l = diff_lane(rd_data, expv);
                $display("FAIL basic_read addr=%0d vld=%b lane=%0d got=%h exp=%h",
                         a, rd_valid, l, rd_data[l*W +: W], expv[l*W +: W]);
            end
        end
        clk_step();
        n_checks++;
        if (rd_valid !== 1'b0 || rd_data !== expv) begin
            n_err++; $display("FAIL basic_hold vld=%b exp vld=0 lane0 got=%h exp=%h", rd_valid, rd_data[W-1:0], expv[W-1:0]);
        end
    endtask

    task automatic test_interleave();
        int            sf_bad, ack_seen, l;
        logic          ack;
        logic [LW-1:0] expv;
        load_page(1, KW, SW, sf_bad, ack_seen);
        n_checks += 2;
        if (sf_bad != 0) begin n_err++; $display("FAIL ilv_full_timing bad_cycles=%0d exp=0", sf_bad); end
        if (shadow_full !== 1'b1 || in_ready !== 1'b0) begin
            n_err++; $display("FAIL ilv_full shadow_full=%b in_ready=%b exp 1/0", shadow_full, in_ready);
        end
        repeat (3) clk_step();
        n_checks++;
        if (shadow_full !== 1'b1) begin n_err++; $display("FAIL ilv_full_hold got=%b exp=1", shadow_full); end
        swap_pages(ack);
        n_checks++;
        if (ack !== 1'b1) begin n_err++; $display("FAIL ilv_swap_ack got=%b exp=1", ack); end
        for (int a = 0; a < D; a++) begin
            rd_en = 1'b1; rd_addr = 4'(a);
            clk_step();
            rd_en = 1'b0;
            expv = exp_line(active_m, a);
            n_checks++;
            if (rd_valid !== 1'b1 || rd_data !== expv) begin
                n_err++; l = diff_lane(rd_data, expv);
                $display("FAIL ilv_read addr=%0d vld=%b lane=%0d got=%h exp=%h",
                         a, rd_valid, l, rd_data[l*W +: W], expv[l*W +: W]);
            end
        end
    endtask

    task automatic test_swap_held();
        int            sf_bad, ack_seen, a, l;
        logic [LW-1:0] expv;
        apply_reset();
        swap_req = 1'b1;
        load_page(0, KW, SW, sf_bad, ack_seen);
        n_checks += 3;
        if (ack_seen != 0) begin n_err++; $display("FAIL held_ack_in_load count=%0d exp=0", ack_seen); end
        if (sf_bad != 0)   begin n_err++; $display("FAIL held_full_timing bad_cycles=%0d exp=0", sf_bad); end
        if (swap_ack !== 1'b1) begin n_err++; $display("FAIL held_ack_after_last got=%b exp=1", swap_ack); end
        a = $urandom_range(0, D - 1);
        rd_en = 1'b1; rd_addr = 4'(a);
        expv = exp_line(active_m, a);
        clk_step();
        active_m ^= 1; kc_m = 0; sc_m = 0;
        n_checks += 2;
        if (rd_data !== expv) begin
            n_err++; l = diff_lane(rd_data, expv);
            $display("FAIL held_ack_cycle_read addr=%0d lane=%0d got=%h exp=%h", a, l, rd_data[l*W +: W], expv[l*W +: W]);
        end
        if (swap_ack !== 1'b0 || in_ready !== 1'b1) begin
            n_err++; $display("FAIL held_after_swap swap_ack=%b in_ready=%b exp 0/1", swap_ack, in_ready);
        end
        a = $urandom_range(0, D - 1);
        rd_addr = 4'(a);
        expv = exp_line(active_m, a);
        clk_step();
        rd_en = 1'b0;
        n_checks++;
        if (rd_valid !== 1'b1 || rd_data !== expv) begin
            n_err++; l = diff_lane(rd_data, expv);
            $display("FAIL held_new_page_read addr=%0d lane=%0d got=%h exp=%h", a, l, rd_data[l*W +: W], expv[l*W +: W]);
        end
        swap_req = 1'b0;
    endtask

    task automatic test_continuous_read();
        int            k, s, a, l;
        logic          ack;
        logic [LW-1:0] expv;
        k = 0; s = 0;
        while (k < KW || s < SW) begin
            a = $urandom_range(0, D - 1);
            rd_en = 1'b1; rd_addr = 4'(a);
            expv = exp_line(active_m, a);
            if (s < SW && k > s) begin put(1'b0, 1'b1, {$urandom, $urandom}); s++; end
            else                 begin put(1'b1, 1'b0, {$urandom, $urandom}); k++; end
            n_checks++;
            if (rd_valid !== 1'b1 || rd_data !== expv) begin
                n_err++; l = diff_lane(rd_data, expv);
                $display("FAIL cont_read k=%0d s=%0d addr=%0d lane=%0d got=%h exp=%h",
                         k, s, a, l, rd_data[l*W +: W], expv[l*W +: W]);
            end
        end
        a = $urandom_range(0, D - 1);
        rd_en = 1'b1; rd_addr = 4'(a);
        expv = exp_line(active_m, a);
        swap_pages(ack);
        n_checks += 2;
        if (ack !== 1'b1) begin n_err++; $display("FAIL cont_swap_ack got=%b exp=1", ack); end
        if (rd_data !== expv) begin
            n_err++; l = diff_lane(rd_data, expv);
            $display("FAIL cont_ack_read addr=%0d lane=%0d got=%h exp=%h", a, l, rd_data[l*W +: W], expv[l*W +: W]);
        end
        a = $urandom_range(0, D - 1);
        rd_addr = 4'(a);
        expv = exp_line(active_m, a);
        clk_step();
        rd_en = 1'b0;
        n_checks++;
        if (rd_data !== expv) begin
            n_err++; l = diff_lane(rd_data, expv);
            $display("FAIL cont_new_read addr=%0d lane=%0d got=%h exp=%h", a, l, rd_data[l*W +: W], expv[l*W +: W]);
        end
    endtask

    task automatic test_error();
        int            sf_bad, ack_seen, l;
        logic          ack;
        logic [LW-1:0] expv;
        load_page(0, KW, SW / 2, sf_bad, ack_seen);
        n_checks++;
        if (err !== 1'b0) begin n_err++; $display("FAIL err_before got=%b exp=0", err); end
        put(1'b1, 1'b0, {$urandom, $urandom});
        n_checks += 2;
        if (err !== 1'b1) begin n_err++; $display("FAIL err_extra_kern got=%b exp=1", err); end
        if (err_m !== 1'b1) begin n_err++; $display("FAIL err_model_flag got=%b exp=1", err_m); end
        put(1'b1, 1'b1, {$urandom, $urandom});
        put(1'b0, 1'b0, {$urandom, $urandom});
        n_checks += 2;
        if (shadow_full !== 1'b0 || in_ready !== 1'b1) begin
            n_err++; $display("FAIL err_state shadow_full=%b in_ready=%b exp 0/1", shadow_full, in_ready);
        end
        if (err !== 1'b1) begin n_err++; $display("FAIL err_sticky got=%b exp=1", err); end
        load_page(0, 0, SW / 2, sf_bad, ack_seen);
        n_checks++;
        if (sf_bad != 0) begin n_err++; $display("FAIL err_full_timing bad_cycles=%0d exp=0", sf_bad); end
        swap_pages(ack);
        n_checks += 2;
        if (ack !== 1'b1) begin n_err++; $display("FAIL err_swap_ack got=%b exp=1", ack); end
        if (err !== 1'b1) begin n_err++; $display("FAIL err_sticky_swap got=%b exp=1", err); end
        for (int a = 0; a < D; a++) begin
            rd_en = 1'b1; rd_addr = 4'(a);
            clk_step();
            rd_en = 1'b0;
            expv = exp_line(active_m, a);
            n_checks++;
            if (rd_valid !== 1'b1 || rd_data !== expv) begin
                n_err++; l = diff_lane(rd_data, expv);
                $display("FAIL err_read addr=%0d vld=%b lane=%0d got=%h exp=%h",
                         a, rd_valid, l, rd_data[l*W +: W], expv[l*W +: W]);
            end
        end
    endtask

    task automatic test_reset_midload();
        int            sf_bad, ack_seen, l;
        logic          ack;
        logic [LW-1:0] expv;
        load_page(0, 200, 0, sf_bad, ack_seen);
        rd_en = 1'b1; rd_addr = 4'(3);
        clk_step();
        #2 rst = 1'b1;
        #1;
        n_checks += 6;
        if (in_ready !== 1'b1)    begin n_err++; $display("FAIL midrst_in_ready got=%b exp=1", in_ready); end
        if (shadow_full !== 1'b0) begin n_err++; $display("FAIL midrst_shadow_full got=%b exp=0", shadow_full); end
        if (swap_ack !== 1'b0)    begin n_err++; $display("FAIL midrst_swap_ack got=%b exp=0", swap_ack); end
        if (rd_valid !== 1'b0)    begin n_err++; $display("FAIL midrst_rd_valid got=%b exp=0", rd_valid); end
        if (rd_data !== '0)       begin n_err++; $display("FAIL midrst_rd_data lane0 got=%h exp=0", rd_data[W-1:0]); end
        if (err !== 1'b0)         begin n_err++; $display("FAIL midrst_err got=%b exp=0", err); end
        apply_reset();
        load_page(1, KW, SW, sf_bad, ack_seen);
        n_checks++;
        if (sf_bad != 0) begin n_err++; $display("FAIL midrst_full_timing bad_cycles=%0d exp=0", sf_bad); end
        swap_pages(ack);
        n_checks++;
        if (ack !== 1'b1) begin n_err++; $display("FAIL midrst_swap_ack got=%b exp=1", ack); end
        for (int a = 0; a < D; a++) begin
            rd_en = 1'b1; rd_addr = 4'(a);
            clk_step();
            rd_en = 1'b0;
            expv = exp_line(active_m, a);
            n_checks++;
            if (rd_valid !== 1'b1 || rd_data !== expv) begin
                n_err++; l = diff_lane(rd_data, expv);
                $display("FAIL midrst_read addr=%0d vld=%b lane=%0d got=%h exp=%h",
                         a, rd_valid, l, rd_data[l*W +: W], expv[l*W +: W]);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        test_reset();
        test_basic();
        test_interleave();
        test_swap_held();
        test_continuous_read();
        test_error();
        test_reset_midload();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
